// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch resolve path: the default PC width,
// the in-flight branch entry layout and the prediction encoding.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic PRED_TAKEN = 1'b1;

  typedef struct packed {
    logic                  pred;
    logic [ADDR_W_DEF-1:0] alt_pc;
  } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Interface between the ID/EX stages and the branch resolve unit.
// The master side drives pushes, resolves and flushes; the slave side is the unit.
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);

  logic              push_valid_i;
  logic              push_pred_i;
  logic [ADDR_W-1:0] push_target_i;
  logic [ADDR_W-1:0] push_fallthru_i;
  logic              resolve_valid_i;
  logic              resolve_taken_i;
  logic              flush_i;
  logic              full_o;
  logic              upd_o;
  logic              upd_result_o;
  logic              flush_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              err_o;
  logic [CNT_W-1:0]  br_cnt_o;
  logic [CNT_W-1:0]  mis_cnt_o;

  modport master (
    output push_valid_i, push_pred_i, push_target_i, push_fallthru_i,
    output resolve_valid_i, resolve_taken_i, flush_i,
    input  full_o, upd_o, upd_result_o, flush_o, redirect_pc_o,
    input  err_o, br_cnt_o, mis_cnt_o
  );

  modport slave (
    input  push_valid_i, push_pred_i, push_target_i, push_fallthru_i,
    input  resolve_valid_i, resolve_taken_i, flush_i,
    output full_o, upd_o, upd_result_o, flush_o, redirect_pc_o,
    output err_o, br_cnt_o, mis_cnt_o
  );

endinterface

// File: rtl/branch_resolve_unit_fifo.sv
// In-order queue of in-flight branches: synchronous push/pop with a clear
// that wins over both; a push while full succeeds only when a pop frees a slot.
module br_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign head_data = mem_r[head_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (clear) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= tail_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues decode-time predictions, compares them with EX
// outcomes, and produces predictor training, mispredict flush/redirect and stats.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  branch_resolve_unit_if.slave bus
);

  localparam int ENT_W = ADDR_W + 1;

  typedef struct packed {
    logic              pred;
    logic [ADDR_W-1:0] alt_pc;
  } entry_t;

  entry_t            push_ent_s;
  entry_t            head_ent_s;
  logic              full_s;
  logic              empty_s;
  logic              res_ok_s;
  logic              mispred_s;
  logic              clear_s;
  logic              err_evt_s;

  logic              upd_r;
  logic              upd_result_r;
  logic              flush_r;
  logic [ADDR_W-1:0] redirect_pc_r;
  logic              err_r;
  logic [CNT_W-1:0]  br_cnt_r;
  logic [CNT_W-1:0]  mis_cnt_r;

  // The stored PC is the one to fetch if the prediction turns out wrong.
  assign push_ent_s.pred   = bus.push_pred_i;
  assign push_ent_s.alt_pc = (bus.push_pred_i == PRED_TAKEN) ? bus.push_fallthru_i
                                                               : bus.push_target_i;

  assign res_ok_s  = bus.resolve_valid_i & ~empty_s;
  assign mispred_s = res_ok_s & (head_ent_s.pred != bus.resolve_taken_i);
  assign clear_s   = bus.flush_i | mispred_s;
  assign err_evt_s = (bus.resolve_valid_i & empty_s)
                   | (bus.push_valid_i & full_s & ~res_ok_s);

  br_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clear     (clear_s),
    .push      (bus.push_valid_i),
    .pop       (res_ok_s),
    .push_data (push_ent_s),
    .head_data (head_ent_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Training/flush pulses, redirect PC, sticky error and saturating counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      upd_r         <= 1'b0;
      upd_result_r  <= 1'b0;
      flush_r       <= 1'b0;
      redirect_pc_r <= {ADDR_W{1'b0}};
      err_r         <= 1'b0;
      br_cnt_r      <= {CNT_W{1'b0}};
      mis_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      upd_r   <= res_ok_s;
      flush_r <= mispred_s & ~bus.flush_i;
      if (res_ok_s) begin
        upd_result_r <= bus.resolve_taken_i;
      end else begin
        upd_result_r <= upd_result_r;
      end
      if (mispred_s && !bus.flush_i) begin
        redirect_pc_r <= head_ent_s.alt_pc;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
      err_r <= err_r | err_evt_s;
      if (res_ok_s && (br_cnt_r != {CNT_W{1'b1}})) begin
        br_cnt_r <= br_cnt_r + CNT_W'(1);
      end else begin
        br_cnt_r <= br_cnt_r;
      end
      if (mispred_s && (mis_cnt_r != {CNT_W{1'b1}})) begin
        mis_cnt_r <= mis_cnt_r + CNT_W'(1);
      end else begin
        mis_cnt_r <= mis_cnt_r;
      end
    end
  end

  assign bus.full_o        = full_s;
  assign bus.upd_o         = upd_r;
  assign bus.upd_result_o  = upd_result_r;
  assign bus.flush_o       = flush_r;
  assign bus.redirect_pc_o = redirect_pc_r;
  assign bus.err_o         = err_r;
  assign bus.br_cnt_o      = br_cnt_r;
  assign bus.mis_cnt_o     = mis_cnt_r;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits between the ID stage and the 2-bit branch predictor.
- Records each prediction made at decode in a small in-order queue. When EX resolves a branch, it compares the actual outcome with the queued prediction.
- Outputs: the predictor training pulse (update/result), a pipeline flush, and the redirect PC on a mispredict.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
- ADDR_W, 32, PC width.
- DEPTH, 2, number of in-flight branch entries (power of 2, ≥2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- push_valid_i  in  1  conditional branch decoded in ID this cycle.
- push_pred_i  in  1  predictor decision for that branch (1 = taken).
- push_target_i  in  ADDR_W  branch target PC.
- push_fallthru_i  in  ADDR_W  PC+4 of the branch.
- resolve_valid_i  in  1  oldest in-flight branch resolved in EX this cycle.
- resolve_taken_i  in  1  actual outcome (1 = taken).
- flush_i  in  1  external flush (exception/jump); discards all entries.
- full_o  out  1  queue full; ID must stall further branches.
- upd_o  out  1  one-cycle pulse to predictor update_i.
- upd_result_o  out  1  actual outcome to predictor result_i; valid when upd_o=1.
- flush_o  out  1  one-cycle mispredict flush pulse.
- redirect_pc_o  out  ADDR_W  correct PC; valid when flush_o=1.
- err_o  out  1  sticky protocol error.
- br_cnt_o  out  CNT_W  branches resolved.
- mis_cnt_o  out  CNT_W  mispredicts.

Behaviour:
- Reset (rst_i=0, async):
  - Queue empty (count=0, pointers 0).
  - All outputs 0, including counters and err_o.
  - Takes effect mid-operation; pending pulses are lost.
- Entry format: {pred, alt_pc}.
  - alt_pc = push_pred_i ? push_fallthru_i : push_target_i, i.e. the PC to fetch if the prediction is wrong.
- Push: on push_valid_i with not full, the entry is written at the tail. full_o is combinational from count==DEPTH.
- Resolve: on resolve_valid_i with not empty, the head is popped and mispredict = head.pred != resolve_taken_i.
- Registered outputs, 1-cycle latency. The cycle after a valid resolve:
  - upd_o=1 and upd_result_o=resolve_taken_i.
  - If mispredict, also flush_o=1 and redirect_pc_o=head.alt_pc.
  - Otherwise flush_o=0 and redirect_pc_o holds its last value.
- Mispredict at the resolve edge:
  - All remaining entries (wrong path) are discarded and count=0.
  - A push in the same cycle is also discarded (wrong-path branch).
- Simultaneous push + correct resolve: pop and push both occur and count is unchanged. This is legal even when full.
- flush_i:
  - Clears the queue at that edge and generates no upd_o/flush_o.
  - If asserted together with resolve_valid_i, the resolve still trains the predictor (upd_o next cycle) but produces no flush_o.
  - Pushes in the same cycle are discarded.
- Errors:
  - Resolve while empty: ignored, no pulse, err_o set.
  - Push while full without a simultaneous pop: dropped, err_o set.
  - err_o clears only on reset.
- Counters:
  - br_cnt_o increments on every valid resolve.
  - mis_cnt_o increments on every mispredict.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W default.
  - Branch entry struct typedef {pred, alt_pc}.
  - Constant PRED_TAKEN=1'b1.
- One natural sub-module: br_fifo, a parameterised synchronous FIFO with push/pop/clear, full/empty and head data.
- Compare logic, output registers and counters live in the top module.

Test Plan:
- Reset mid-stream: push 2 entries, pull rst_i low async → full_o=0, upd_o=0, flush_o=0, counters=0. A subsequent resolve sets err_o=1.
- Correct prediction:
  - Stimulus: push pred=1, target=0x100, fallthru=0x44; resolve taken=1 two cycles later.
  - Expected: next cycle upd_o=1, upd_result_o=1, flush_o=0; br_cnt_o=1, mis_cnt_o=0.
- Mispredict with younger entry:
  - Stimulus: push (pred=1, fallthru=0x44), then push (pred=0, target=0x200); resolve taken=0.
  - Expected: next cycle flush_o=1, redirect_pc_o=0x44, upd_result_o=0; queue empty (full_o=0). A following resolve sets err_o=1.
- Full boundary (DEPTH=2):
  - Stimulus: push, push → full_o=1. Then push+correct resolve in the same cycle.
  - Expected: count stays 2 with no err_o. A push alone then sets err_o=1 and is dropped.
- flush_i with resolve: flush_i=1 together with resolve taken=1 (pred=0) → upd_o=1, upd_result_o=1, flush_o=0; queue empty.
- Counter saturation (CNT_W=4): 17 mispredicting resolves → mis_cnt_o=15 and br_cnt_o=15.
